// File: rtl/tube_pkg.sv
// Shared constants for the 4-digit 7-segment tube controller: bus addresses,
// control-register bit positions and the all-dark output pattern.
package tube_pkg;
  localparam logic [31:0] ADDR_DATA_DFLT = 32'h4000_0010;
  localparam logic [31:0] ADDR_CTRL_DFLT = 32'h4000_0014;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_RAW       = 1;
  localparam int CTRL_DP_LSB    = 4;
  localparam int CTRL_BLANK_LSB = 8;

  // Bits [3:2] of the control register are reserved and always read back 0.
  localparam logic [11:0] CTRL_WMASK = 12'hFF3;
  localparam logic [11:0] CTRL_RST   = 12'h001;
  localparam logic [11:0] BCD7_DARK  = 12'hFFF;
endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern, bit order g..a.
module hex_to_seg7 (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

// File: rtl/digit_tube_ctrl.sv
// Memory-mapped 4-digit 7-segment controller: data/ctrl registers on the CPU
// bus, hardware digit scanning and a registered BCD7 = {an, dp, g..a} output.
module digit_tube_ctrl
  import tube_pkg::*;
#(
  parameter logic [31:0] ADDR_DATA = ADDR_DATA_DFLT,
  parameter logic [31:0] ADDR_CTRL = ADDR_CTRL_DFLT,
  parameter int          SCAN_DIV  = 100000,
  parameter int          SCAN_W    = 17
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [11:0] BCD7
);
  logic [15:0]       data_q, data_d;
  logic [11:0]       ctrl_q, ctrl_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [11:0]       bcd7_q, bcd7_d;
  logic [6:0]        seg;
  logic [3:0]        nib, dp_mask, blank_mask, an;

  logic wr_data, wr_ctrl;
  assign wr_data = mem_write && (addr == ADDR_DATA);
  assign wr_ctrl = mem_write && (addr == ADDR_CTRL);

  // Reads see the registered value, so a same-cycle write returns old data.
  always_comb begin
    rdata = 32'h0;
    if (mem_read) begin
      if (addr == ADDR_DATA)      rdata = {16'h0, data_q};
      else if (addr == ADDR_CTRL) rdata = {20'h0, ctrl_q};
    end
  end

  always_comb begin
    data_d     = wr_data ? wdata[15:0] : data_q;
    ctrl_d     = wr_ctrl ? (wdata[11:0] & CTRL_WMASK) : ctrl_q;
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (wr_ctrl) begin
      scan_cnt_d = '0;
      idx_d      = 2'd0;
    end else if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end
  end

  assign nib        = data_q[{idx_q, 2'b00} +: 4];
  assign dp_mask    = ctrl_q[CTRL_DP_LSB +: 4];
  assign blank_mask = ctrl_q[CTRL_BLANK_LSB +: 4];
  assign an         = ~(4'b0001 << idx_q);

  hex_to_seg7 u_dec (
    .hex_i (nib),
    .seg_o (seg)
  );

  // Output follows the registers as they stand after the previous edge,
  // so a write at edge N shows up at edge N+1.
  always_comb begin
    bcd7_d = BCD7_DARK;
    if (!ctrl_q[CTRL_EN])        bcd7_d = BCD7_DARK;
    else if (ctrl_q[CTRL_RAW])   bcd7_d = data_q[11:0];
    else if (blank_mask[idx_q])  bcd7_d = BCD7_DARK;
    else                         bcd7_d = {an, ~dp_mask[idx_q], seg};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= 16'h0;
      ctrl_q     <= CTRL_RST;
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      bcd7_q     <= BCD7_DARK;
    end else begin
      data_q     <= data_d;
      ctrl_q     <= ctrl_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      bcd7_q     <= bcd7_d;
    end
  end

  assign BCD7 = bcd7_q;

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];
endmodule

// File: tb/tb_digit_tube_ctrl.sv
// Scoreboarded bench for digit_tube_ctrl with a short scan period.
module tb_digit_tube_ctrl;
  localparam logic [31:0] A_DATA = 32'h4000_0010;
  localparam logic [31:0] A_CTRL = 32'h4000_0014;
  localparam logic [31:0] A_BAD  = 32'h4000_0018;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_write = 1'b0, mem_read = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic [11:0] BCD7;

  int checks = 0, errors = 0;
  logic [11:0] sb[$];

  logic [15:0] m_data = 16'h0;
  logic [11:0] m_ctrl = 12'h001;
  int          m_cnt  = 0;
  logic [1:0]  m_idx  = 2'd0;

  digit_tube_ctrl #(
    .ADDR_DATA (A_DATA),
    .ADDR_CTRL (A_CTRL),
    .SCAN_DIV  (4),
    .SCAN_W    (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .BCD7      (BCD7)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[h];
  endfunction

  function automatic logic [11:0] exp_bcd(input logic [15:0] d, input logic [11:0] c,
                                          input logic [1:0] i);
    logic [3:0] an;
    if (!c[0]) return 12'hFFF;
    if (c[1]) return d[11:0];
    if (c[8+i]) return 12'hFFF;
    an = ~(4'b0001 << i);
    return {an, ~c[4+i], seg_of(d[4*i +: 4])};
  endfunction

  task automatic model_reset;
    m_data = 16'h0; m_ctrl = 12'h001; m_cnt = 0; m_idx = 2'd0;
  endtask

  // One clock: queue the value BCD7 must take at this edge, then advance the model.
  task automatic tb_edge;
    if (!reset) sb.push_back(12'hFFF);
    else sb.push_back(exp_bcd(m_data, m_ctrl, m_idx));
    @(posedge clk);
    if (reset) begin
      if (mem_write && addr == A_DATA) m_data = wdata[15:0];
      if (mem_write && addr == A_CTRL) begin
        m_ctrl = wdata[11:0] & 12'hFF3; m_cnt = 0; m_idx = 2'd0;
      end else if (m_cnt == 3) begin
        m_cnt = 0; m_idx = m_idx + 2'd1;
      end else m_cnt++;
    end
    #1;
  endtask

  task automatic test_reset;
    logic [11:0] e;
    logic [11:0] ks [4] = '{12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0};
    #1 reset = 1'b0;
    #2;
    checks++;
    if (BCD7 !== 12'hFFF) begin errors++; $display("FAIL reset_bcd7 got %h exp fff", BCD7); end
    mem_read = 1'b1; addr = A_DATA; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", rdata); end
    addr = A_CTRL; #1;
    checks++;
    if (rdata !== 32'h1) begin errors++; $display("FAIL reset_ctrl got %h exp 1", rdata); end
    mem_read = 1'b0; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rd_idle got %h exp 0", rdata); end
    model_reset();
    for (int k = 0; k < 2; k++) begin
      tb_edge(); e = sb.pop_front(); checks++;
      if (BCD7 !== e) begin errors++; $display("FAIL reset_hold got %h exp %h", BCD7, e); end
    end
    reset = 1'b1;
    for (int k = 0; k < 18; k++) begin
      tb_edge(); e = sb.pop_front(); checks++;
      if (BCD7 !== e || BCD7 !== ks[(k/4)%4]) begin
        errors++; $display("FAIL idle_scan k %0d got %h exp %h / %h", k, BCD7, e, ks[(k/4)%4]);
      end
    end
  endtask

  task automatic test_data;
    logic [11:0] e;
    logic [11:0] ks [4] = '{12'hE99, 12'hDB0, 12'hBA4, 12'h7F9};
    mem_write = 1'b1; addr = A_DATA; wdata = 32'hFFFF_1234;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e) begin errors++; $display("FAIL data_wr got %h exp %h", BCD7, e); end
    mem_write = 1'b0; mem_read = 1'b1; #1;
    checks++;
    if (rdata !== 32'h0000_1234) begin errors++; $display("FAIL data_rd got %h exp 00001234", rdata); end
    mem_read = 1'b0;
    mem_write = 1'b1; addr = A_CTRL; wdata = 32'h1;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e) begin errors++; $display("FAIL data_restart got %h exp %h", BCD7, e); end
    mem_write = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tb_edge(); e = sb.pop_front(); checks++;
      if (BCD7 !== e || BCD7 !== ks[k/4]) begin
        errors++; $display("FAIL data_scan k %0d got %h exp %h / %h", k, BCD7, e, ks[k/4]);
      end
    end
  endtask

  task automatic test_dp;
    logic [11:0] e;
    mem_write = 1'b1; addr = A_CTRL; wdata = 32'h0011;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e) begin errors++; $display("FAIL dp_wr got %h exp %h", BCD7, e); end
    mem_write = 1'b0;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e || BCD7 !== 12'hE19) begin errors++; $display("FAIL dp_1234 got %h exp e19", BCD7); end
    mem_write = 1'b1; addr = A_DATA; wdata = 32'h0;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e) begin errors++; $display("FAIL dp_wr0 got %h exp %h", BCD7, e); end
    mem_write = 1'b0;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e || BCD7 !== 12'hE40) begin errors++; $display("FAIL dp_0 got %h exp e40", BCD7); end
  endtask

  task automatic test_raw;
    logic [11:0] e;
    mem_write = 1'b1; addr = A_CTRL; wdata = 32'h0003;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e) begin errors++; $display("FAIL raw_ctrl got %h exp %h", BCD7, e); end
    addr = A_DATA; wdata = 32'h0ABC;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e) begin errors++; $display("FAIL raw_data got %h exp %h", BCD7, e); end
    mem_write = 1'b0;
    for (int k = 0; k < 18; k++) begin
      tb_edge(); e = sb.pop_front(); checks++;
      if (BCD7 !== e || BCD7 !== 12'hABC) begin errors++; $display("FAIL raw_hold k %0d got %h exp abc", k, BCD7); end
    end
    mem_write = 1'b1; addr = A_CTRL; wdata = 32'h0;
    tb_edge(); void'(sb.pop_front());
    mem_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tb_edge(); e = sb.pop_front(); checks++;
      if (BCD7 !== e || BCD7 !== 12'hFFF) begin errors++; $display("FAIL raw_off k %0d got %h exp fff", k, BCD7); end
    end
  endtask

  task automatic test_rw_same;
    logic [11:0] e;
    mem_read = 1'b1; mem_write = 1'b1; addr = A_CTRL; wdata = 32'hFFFF_0F0D;
    #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL rw_old got %h exp 0", rdata); end
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e) begin errors++; $display("FAIL rw_edge got %h exp %h", BCD7, e); end
    mem_write = 1'b0; #1;
    checks++;
    if (rdata !== 32'h0F01) begin errors++; $display("FAIL rw_new got %h exp 00000f01", rdata); end
    mem_read = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tb_edge(); e = sb.pop_front(); checks++;
      if (BCD7 !== e || BCD7 !== 12'hFFF) begin errors++; $display("FAIL blank_all k %0d got %h exp fff", k, BCD7); end
    end
  endtask

  task automatic test_reset_mid;
    logic [11:0] e;
    mem_write = 1'b1; addr = A_DATA; wdata = 32'h1234;
    tb_edge(); void'(sb.pop_front());
    addr = A_CTRL; wdata = 32'h1;
    tb_edge(); void'(sb.pop_front());
    mem_write = 1'b0;
    for (int k = 0; k < 9; k++) begin tb_edge(); e = sb.pop_front(); end
    checks++;
    if (BCD7 !== e || BCD7 !== 12'hBA4) begin errors++; $display("FAIL mid_idx2 got %h exp ba4", BCD7); end
    reset = 1'b0; #1;
    checks++;
    if (BCD7 !== 12'hFFF) begin errors++; $display("FAIL mid_rst got %h exp fff", BCD7); end
    model_reset();
    mem_read = 1'b1; addr = A_DATA; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL mid_data got %h exp 0", rdata); end
    addr = A_CTRL; #1;
    checks++;
    if (rdata !== 32'h1) begin errors++; $display("FAIL mid_ctrl got %h exp 1", rdata); end
    mem_read = 1'b0;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e) begin errors++; $display("FAIL mid_hold got %h exp %h", BCD7, e); end
    reset = 1'b1;
    mem_write = 1'b1; addr = A_BAD; wdata = 32'hFFFF_FFFF;
    tb_edge(); e = sb.pop_front(); checks++;
    if (BCD7 !== e || BCD7 !== 12'hEC0) begin errors++; $display("FAIL bad_addr_out got %h exp ec0", BCD7); end
    mem_write = 1'b0; mem_read = 1'b1; addr = A_DATA; #1;
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL bad_data got %h exp 0", rdata); end
    addr = A_CTRL; #1;
    checks++;
    if (rdata !== 32'h1) begin errors++; $display("FAIL bad_ctrl got %h exp 1", rdata); end
    mem_read = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tb_edge(); e = sb.pop_front(); checks++;
      if (BCD7 !== e) begin errors++; $display("FAIL bad_scan k %0d got %h exp %h", k, BCD7, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] e;
    logic [31:0] er;
    int sel;
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      mem_write = ($urandom_range(0, 2) != 0);
      addr  = (sel < 6) ? A_DATA : (sel < 8) ? A_CTRL : A_BAD;
      wdata = $urandom;
      if (addr == A_CTRL) wdata[1] = ($urandom_range(0, 3) == 0);
      if (addr == A_CTRL) wdata[0] = 1'b1;
      mem_read = 1'b1; #1;
      er = (addr == A_DATA) ? {16'h0, m_data} : (addr == A_CTRL) ? {20'h0, m_ctrl} : 32'h0;
      checks++;
      if (rdata !== er) begin errors++; $display("FAIL b2b_rd k %0d got %h exp %h", k, rdata, er); end
      tb_edge(); e = sb.pop_front(); checks++;
      if (BCD7 !== e) begin errors++; $display("FAIL b2b_out k %0d got %h exp %h", k, BCD7, e); end
    end
    mem_write = 1'b0; mem_read = 1'b0;
  endtask

  initial begin
    test_reset();
    test_data();
    test_dp();
    test_raw();
    test_rw_same();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
